// File: rtl/music_player.sv
// Beat-sequenced square-wave tone player: steps beat_num through a song at BEAT_HZ
// and drives audio_out from a phase accumulator fed by the externally looked-up tone.
module music_player #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BEAT_HZ    = 8,
    parameter int LAST_BEAT  = 59,
    parameter int LOOP       = 1,
    parameter int SILENCE_HZ = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        play,
    input  logic        restart,
    input  logic [23:0] tone,
    output logic [7:0]  beat_num,
    output logic        audio_out,
    output logic        beat_tick,
    output logic        playing,
    output logic        done
);

    localparam logic [31:0] DIV_MAX = 32'(CLK_HZ / BEAT_HZ - 1);
    localparam logic [32:0] CLK_W   = 33'(CLK_HZ);
    localparam logic [31:0] SIL_W   = 32'(SILENCE_HZ);
    localparam logic [7:0]  LAST_W  = 8'(LAST_BEAT);
    localparam bit          WRAP    = (LOOP != 0);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] div_q, div_d;
    logic [7:0]  beat_q, beat_d;
    logic        tick_q, tick_d;
    logic [23:0] tone_q;
    logic [31:0] acc_q, acc_d;
    logic        aud_q, aud_d;

    logic        boundary;
    logic        at_last;
    logic        silent;
    logic [32:0] sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            beat_q  <= '0;
            tick_q  <= 1'b0;
            tone_q  <= '0;
            acc_q   <= '0;
            aud_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            beat_q  <= beat_d;
            tick_q  <= tick_d;
            tone_q  <= tone;
            acc_q   <= acc_d;
            aud_q   <= aud_d;
        end
    end

    // Sequencer: restart wins over every other event in its cycle.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        beat_d   = beat_q;
        tick_d   = 1'b0;
        boundary = (state_q == S_PLAY) && (div_q == DIV_MAX);
        at_last  = (beat_q == LAST_W);
        if (restart) begin
            state_d = play ? S_PLAY : S_IDLE;
            div_d   = '0;
            beat_d  = '0;
        end else begin
            case (state_q)
                S_IDLE:  if (play) state_d = S_PLAY;
                S_PLAY: begin
                    div_d = boundary ? '0 : div_q + 32'd1;
                    if (boundary && !at_last) begin
                        beat_d = beat_q + 8'd1;
                        tick_d = 1'b1;
                    end else if (boundary && WRAP) begin
                        beat_d = '0;
                        tick_d = 1'b1;
                    end
                    if (boundary && at_last && !WRAP) state_d = S_DONE;
                    else if (!play)                   state_d = S_PAUSE;
                end
                S_PAUSE: if (play) state_d = S_PLAY;
                default: ;
            endcase
        end
    end

    // Phase accumulator advances 2*f per clock so audio_out toggles f*2 times per second.
    always_comb begin
        acc_d  = acc_q;
        aud_d  = aud_q;
        silent = (tone_q == 24'd0) || ({8'd0, tone_q} >= SIL_W);
        sum    = {1'b0, acc_q} + {8'd0, tone_q, 1'b0};
        if (restart || (state_q != S_PLAY) || silent) begin
            acc_d = '0;
            aud_d = 1'b0;
        end else if (tone != tone_q) begin
            acc_d = '0;
        end else if (sum >= CLK_W) begin
            acc_d = 32'(sum - CLK_W);
            aud_d = ~aud_q;
        end else begin
            acc_d = sum[31:0];
        end
    end

    assign beat_num  = beat_q;
    assign beat_tick = tick_q;
    assign audio_out = aud_q;
    assign playing   = (state_q == S_PLAY);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_music_player.sv
// Bench for music_player: two instances (LOOP=0 and LOOP=1) share stimulus and are
// compared every cycle against an arithmetic model of the song/tone behaviour.
module tb_music_player;

    localparam int CLK  = 1000;
    localparam int BLEN = 100;
    localparam int LAST = 3;
    localparam int SIL  = 20000;
    localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_DONE = 3;

    logic        clk;
    logic        rst_n;
    logic        play;
    logic        restart;
    logic [23:0] tone;
    logic [7:0]  bn   [2];
    logic        aud  [2];
    logic        tick [2];
    logic        ply  [2];
    logic        dn   [2];

    int n_cmp;
    int n_err;

    int     m_mode   [2];
    int     m_elapsed[2];
    int     m_beat   [2];
    int     m_tone_q [2];
    bit     m_tick   [2];
    bit     m_lvl    [2];
    bit     m_base   [2];
    longint m_n      [2];

    music_player #(.CLK_HZ(CLK), .BEAT_HZ(10), .LAST_BEAT(LAST), .LOOP(0), .SILENCE_HZ(SIL)) u_once (
        .clk(clk), .rst_n(rst_n), .play(play), .restart(restart), .tone(tone),
        .beat_num(bn[0]), .audio_out(aud[0]), .beat_tick(tick[0]), .playing(ply[0]), .done(dn[0])
    );

    music_player #(.CLK_HZ(CLK), .BEAT_HZ(10), .LAST_BEAT(LAST), .LOOP(1), .SILENCE_HZ(SIL)) u_loop (
        .clk(clk), .rst_n(rst_n), .play(play), .restart(restart), .tone(tone),
        .beat_num(bn[1]), .audio_out(aud[1]), .beat_tick(tick[1]), .playing(ply[1]), .done(dn[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = M_IDLE; m_elapsed[k] = 0; m_beat[k] = 0; m_tone_q[k] = 0;
            m_tick[k] = 0; m_lvl[k] = 0; m_base[k] = 0; m_n[k] = 0;
        end
    endtask

    // Audio level = level at last accumulator clear XOR parity of completed wraps,
    // where wraps after n cycles = floor(n * 2f / CLK).
    task automatic model_step(input int k);
        int tq;
        bit silent;
        tq = m_tone_q[k];
        silent = (tq == 0) || (tq >= SIL);
        if (restart || m_mode[k] != M_PLAY || silent) begin
            m_lvl[k] = 0; m_n[k] = 0; m_base[k] = 0;
        end else if (int'(tone) != tq) begin
            m_n[k] = 0; m_base[k] = m_lvl[k];
        end else begin
            m_n[k]++;
            m_lvl[k] = m_base[k] ^ ((((m_n[k] * 2 * longint'(tq)) / CLK) % 2) != 0);
        end
        m_tone_q[k] = int'(tone);
        m_tick[k] = 0;
        if (restart) begin
            m_beat[k] = 0; m_elapsed[k] = 0;
            m_mode[k] = play ? M_PLAY : M_IDLE;
        end else begin
            case (m_mode[k])
                M_IDLE, M_PAUSE: if (play) m_mode[k] = M_PLAY;
                M_PLAY: begin
                    m_elapsed[k]++;
                    if (m_elapsed[k] == BLEN) begin
                        m_elapsed[k] = 0;
                        if (m_beat[k] < LAST) begin
                            m_beat[k]++; m_tick[k] = 1;
                        end else if (k == 1) begin
                            m_beat[k] = 0; m_tick[k] = 1;
                        end else begin
                            m_mode[k] = M_DONE;
                        end
                    end
                    if (m_mode[k] == M_PLAY && !play) m_mode[k] = M_PAUSE;
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("beat_num[L%0d]", k),  32'(bn[k]),   32'(m_beat[k]));
            chk($sformatf("beat_tick[L%0d]", k), 32'(tick[k]), 32'(m_tick[k]));
            chk($sformatf("audio_out[L%0d]", k), 32'(aud[k]),  32'(m_lvl[k]));
            chk($sformatf("playing[L%0d]", k),   32'(ply[k]),  32'(m_mode[k] == M_PLAY));
            chk($sformatf("done[L%0d]", k),      32'(dn[k]),   32'(m_mode[k] == M_DONE));
        end
    endtask

    task automatic cycle_chk();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle_chk();
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s beat_num[L%0d]", tag, k),  32'(bn[k]),   32'd0);
            chk($sformatf("%s beat_tick[L%0d]", tag, k), 32'(tick[k]), 32'd0);
            chk($sformatf("%s audio_out[L%0d]", tag, k), 32'(aud[k]),  32'd0);
            chk($sformatf("%s playing[L%0d]", tag, k),   32'(ply[k]),  32'd0);
            chk($sformatf("%s done[L%0d]", tag, k),      32'(dn[k]),   32'd0);
        end
    endtask

    initial begin
        int tones[7];
        int guard;
        tones = '{250, 100, 300, 20000, 0, 333, 125};
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0; play = 1'b0; restart = 1'b0; tone = 24'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // No self-start while play is low.
        run(20);

        // Constant 250 Hz tone, looping song; LOOP=0 instance stops after beat 3.
        tone = 24'd250;
        play = 1'b1;
        run(450);

        // Restart out of DONE with play held high.
        restart = 1'b1;
        cycle_chk();
        restart = 1'b0;

        // Pause 40 clocks into beat 1, hold 500, resume.
        run(140);
        play = 1'b0;
        run(500);
        play = 1'b1;
        run(100);

        // Tone at the silence threshold.
        tone = 24'd20000;
        run(50);
        tone = 24'd250;
        run(20);

        // Restart landing on a beat boundary.
        guard = 0;
        while (!(m_mode[1] == M_PLAY && m_elapsed[1] == BLEN - 1) && guard < 300) begin
            cycle_chk();
            guard++;
        end
        if (guard >= 300) begin
            n_cmp++; n_err++;
            $error("FAIL boundary_wait: observed timeout expected boundary within 300 clk");
        end
        restart = 1'b1;
        cycle_chk();
        restart = 1'b0;
        run(5);

        // Randomized play/restart/tone activity.
        for (int i = 0; i < 1500; i++) begin
            play    = ($urandom_range(0, 99) < 92);
            restart = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) tone = 24'(tones[$urandom_range(0, 6)]);
            cycle_chk();
        end
        restart = 1'b0;
        play = 1'b1;
        tone = 24'd250;
        restart = 1'b1;
        cycle_chk();
        restart = 1'b0;

        // Asynchronous reset 30 clocks into beat 2, between clock edges.
        run(230);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(negedge clk);
        check_zero("reset_held");
        rst_n = 1'b1;
        run(250);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
